// File: rtl/vga_sync_rx_pkg.sv
// Shared definitions for the VGA receive path: 640x480 timing defaults,
// lock-state encoding, the packed 9-bit pixel type and a wrap helper.
package vga_pkg;

    localparam int VGA_H_ACTIVE     = 640;
    localparam int VGA_H_SYNC_START = 656;
    localparam int VGA_H_SYNC_END   = 752;
    localparam int VGA_H_TOTAL      = 800;
    localparam int VGA_V_ACTIVE     = 480;
    localparam int VGA_V_SYNC_START = 490;
    localparam int VGA_V_SYNC_END   = 492;
    localparam int VGA_V_TOTAL      = 525;
    localparam int VGA_LOCK_FRAMES  = 2;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } lock_state_t;

    typedef struct packed {
        logic [2:0] red;
        logic [2:0] green;
        logic [2:0] blue;
    } rgb9_t;

    // Increment a 10-bit position counter, wrapping total-1 back to 0.
    function automatic logic [9:0] wrap_inc(input logic [9:0] v, input int total);
        return (v == 10'(total - 1)) ? 10'd0 : v + 10'd1;
    endfunction

endpackage

// File: rtl/vga_sync_rx_if.sv
// Capture bus from the VGA receiver to a downstream capture/checker.
// pixel_valid qualifies pixel, row and col for exactly one clk; there is no
// ready/backpressure, so the consumer must accept every valid beat.
// row and col are meaningful on every cycle and show the latest sample.
interface vga_sync_rx_if
    import vga_pkg::*;
;
    logic [9:0] row;
    logic [9:0] col;
    logic       pixel_valid;
    rgb9_t      pixel;

    modport master (output row, col, pixel_valid, pixel);
    modport slave  (input  row, col, pixel_valid, pixel);
endinterface

// File: rtl/vga_sync_rx_sync_2ff.sv
// Parameterised-width two-stage synchronizer with asynchronous reset to a
// configurable value, so idle-high syncs do not produce a false edge.
module sync_2ff #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] s1;

    // Two flops in series; all bits move together to keep them aligned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= RST_VAL;
            q  <= RST_VAL;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end
endmodule

// File: rtl/vga_sync_rx.sv
// VGA receiver: synchronizes sync/RGB pins, rebuilds row/col by aligning to
// sync falling edges, tracks lock over whole frames and emits active pixels.
// Optional macro VGA_SYNC_WIDTH_CHECK_EN: also check sync rising edges
// (pulse width) and treat a mismatch as an alignment error (no forcing).
module vga_sync_rx
    import vga_pkg::*;
#(
    parameter int H_ACTIVE     = VGA_H_ACTIVE,
    parameter int H_SYNC_START = VGA_H_SYNC_START,
    parameter int H_SYNC_END   = VGA_H_SYNC_END,
    parameter int H_TOTAL      = VGA_H_TOTAL,
    parameter int V_ACTIVE     = VGA_V_ACTIVE,
    parameter int V_SYNC_START = VGA_V_SYNC_START,
    parameter int V_SYNC_END   = VGA_V_SYNC_END,
    parameter int V_TOTAL      = VGA_V_TOTAL,
    parameter int LOCK_FRAMES  = VGA_LOCK_FRAMES
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pixel_en,
    input  logic          hsync,
    input  logic          vsync,
    input  logic [2:0]    red,
    input  logic [2:0]    green,
    input  logic [2:0]    blue,
    vga_sync_rx_if.master cap,
    output logic          locked,
    output logic [15:0]   frame_count,
    output logic [7:0]    err_count,
    output lock_state_t   state_dbg
);
`ifdef VGA_SYNC_WIDTH_CHECK_EN
    localparam bit WIDTH_CHECK = 1'b1;
`else
    localparam bit WIDTH_CHECK = 1'b0;
`endif
    localparam int          CW       = $clog2(LOCK_FRAMES + 1);
    localparam logic [10:0] SYNC_RST = {2'b11, 9'b0};

    logic [10:0] sync_q;
    logic        hs_s, vs_s;
    rgb9_t       rgb_s;

    sync_2ff #(.WIDTH(11), .RST_VAL(SYNC_RST)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   ({hsync, vsync, red, green, blue}),
        .q   (sync_q)
    );

    assign hs_s  = sync_q[10];
    assign vs_s  = sync_q[9];
    assign rgb_s = sync_q[8:0];

    logic [9:0]  row_q, col_q, nom_col, nom_row, new_col, new_row;
    logic        hs_prev, vs_prev, pv_q;
    rgb9_t       pix_q;
    logic        hs_fall, vs_fall, h_err, v_err, w_err, any_err;
    lock_state_t state_q, state_d;
    logic [CW-1:0] clean_q, clean_d;
    logic        dirty_q, dirty_d;
    logic [15:0] frame_q, frame_d;
    logic [7:0]  err_q, err_d;

    // Nominal advance, edge detection and sync-driven realignment.
    always_comb begin
        nom_col = wrap_inc(col_q, H_TOTAL);
        nom_row = (col_q == 10'(H_TOTAL - 1)) ? wrap_inc(row_q, V_TOTAL) : row_q;
        hs_fall = hs_prev && !hs_s;
        vs_fall = vs_prev && !vs_s;
        h_err   = hs_fall && (nom_col != 10'(H_SYNC_START));
        v_err   = vs_fall && ((nom_row != 10'(V_SYNC_START)) || (nom_col != 10'd0));
        w_err   = WIDTH_CHECK &&
                  (((!hs_prev && hs_s) && (nom_col != 10'(H_SYNC_END))) ||
                   ((!vs_prev && vs_s) && (nom_row != 10'(V_SYNC_END))));
        any_err = h_err || v_err || w_err;
        new_col = nom_col;
        new_row = nom_row;
        if (h_err) new_col = 10'(H_SYNC_START);
        if (v_err) begin
            new_col = 10'd0;
            new_row = 10'(V_SYNC_START);
        end
    end

    // Lock FSM next state plus frame/error counters, advancing only on samples.
    always_comb begin
        state_d = state_q;
        clean_d = clean_q;
        dirty_d = dirty_q;
        frame_d = frame_q;
        err_d   = err_q;
        if (pixel_en) begin
            case (state_q)
                SEARCH: begin
                    if (vs_fall) begin
                        state_d = VERIFY;
                        clean_d = '0;
                        dirty_d = 1'b0;
                    end
                end
                VERIFY: begin
                    if (vs_fall) begin
                        dirty_d = 1'b0;
                        if (any_err || dirty_q) begin
                            clean_d = '0;
                        end else if (clean_q == CW'(LOCK_FRAMES - 1)) begin
                            clean_d = '0;
                            state_d = LOCKED;
                        end else begin
                            clean_d = clean_q + CW'(1);
                        end
                    end else if (any_err) begin
                        clean_d = '0;
                        dirty_d = 1'b1;
                    end
                end
                LOCKED: begin
                    if (any_err) begin
                        state_d = SEARCH;
                        err_d   = (err_q == 8'hFF) ? err_q : err_q + 8'd1;
                    end else if (vs_fall) begin
                        frame_d = frame_q + 16'd1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // Lock FSM and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SEARCH;
            clean_q <= '0;
            dirty_q <= 1'b0;
            frame_q <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            clean_q <= clean_d;
            dirty_q <= dirty_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    // Position, previous-sync and registered capture outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            hs_prev <= 1'b1;
            vs_prev <= 1'b1;
            pv_q    <= 1'b0;
            pix_q   <= '0;
        end else begin
            pv_q <= 1'b0;
            if (pixel_en) begin
                row_q   <= new_row;
                col_q   <= new_col;
                hs_prev <= hs_s;
                vs_prev <= vs_s;
                pix_q   <= rgb_s;
                pv_q    <= (state_d == LOCKED) && (new_row < 10'(V_ACTIVE)) &&
                           (new_col < 10'(H_ACTIVE));
            end
        end
    end

    assign cap.row         = row_q;
    assign cap.col         = col_q;
    assign cap.pixel_valid = pv_q;
    assign cap.pixel       = pix_q;
    assign locked          = (state_q == LOCKED);
    assign frame_count     = frame_q;
    assign err_count       = err_q;
    assign state_dbg       = state_q;
endmodule

// File: tb/tb_vga_sync_rx.sv
// Bench for vga_sync_rx with shrunk timing so whole frames stay short.
// A transmitter task drives pins; a frame-level model predicts outputs.
module tb_vga_sync_rx;
    import vga_pkg::*;

    localparam int HA = 24, HSS = 26, HSE = 30, HT = 34;
    localparam int VA = 12, VSS = 13, VSE = 15, VT = 18;
    localparam int LF = 2;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
    localparam bit WCHK = 1'b1;
`else
    localparam bit WCHK = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1, pixel_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [2:0] red = '0, green = '0, blue = '0;
    logic locked;
    logic [15:0] frame_count;
    logic [7:0] err_count;
    lock_state_t state_dbg;

    vga_sync_rx_if cap ();

    vga_sync_rx #(
        .H_ACTIVE(HA), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
        .V_ACTIVE(VA), .V_SYNC_START(VSS), .V_SYNC_END(VSE), .V_TOTAL(VT),
        .LOCK_FRAMES(LF)
    ) dut (
        .clk(clk), .rst(rst), .pixel_en(pixel_en), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .cap(cap), .locked(locked),
        .frame_count(frame_count), .err_count(err_count), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;
    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0, n_errors = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [28:0] exp_q[$];
    logic [10:0] hist0, hist1;
    int  m_row, m_col, m_state, m_clean, m_fc, m_ec;
    logic m_hsp, m_vsp, m_dirty, m_pv;

    task automatic m_reset();
        hist0 = {2'b11, 9'b0};
        hist1 = {2'b11, 9'b0};
        m_row = 0; m_col = 0; m_state = 0; m_clean = 0; m_fc = 0; m_ec = 0;
        m_hsp = 1'b1; m_vsp = 1'b1; m_dirty = 1'b0; m_pv = 1'b0;
        exp_q.delete();
    endtask

    task automatic m_step();
        logic [10:0] smp;
        logic shs, svs, hf, vf, he, ve, we, err;
        int ncol, nrow;
        smp   = hist1;
        hist1 = hist0;
        hist0 = {hsync, vsync, red, green, blue};
        m_pv  = 1'b0;
        if (pixel_en) begin
            shs  = smp[10];
            svs  = smp[9];
            ncol = (m_col + 1) % HT;
            nrow = (m_col == HT - 1) ? (m_row + 1) % VT : m_row;
            hf   = m_hsp && !shs;
            vf   = m_vsp && !svs;
            he   = hf && (ncol != HSS);
            ve   = vf && (nrow != VSS || ncol != 0);
            we   = WCHK && (((!m_hsp && shs) && ncol != HSE) || ((!m_vsp && svs) && nrow != VSE));
            err  = he || ve || we;
            m_col = ve ? 0 : (he ? HSS : ncol);
            m_row = ve ? VSS : nrow;
            m_hsp = shs;
            m_vsp = svs;
            if (m_state == 0) begin
                if (vf) begin m_state = 1; m_clean = 0; m_dirty = 1'b0; end
            end else if (m_state == 1) begin
                if (vf) begin
                    if (err || m_dirty) m_clean = 0;
                    else m_clean++;
                    m_dirty = 1'b0;
                    if (m_clean == LF) begin m_state = 2; m_clean = 0; end
                end else if (err) begin
                    m_clean = 0;
                    m_dirty = 1'b1;
                end
            end else begin
                if (err) begin
                    m_ec = (m_ec < 255) ? m_ec + 1 : 255;
                    m_state = 0;
                end else if (vf) begin
                    m_fc = (m_fc + 1) % 65536;
                end
            end
            if (m_state == 2 && m_row < VA && m_col < HA) begin
                m_pv = 1'b1;
                exp_q.push_back({10'(m_row), 10'(m_col), smp[8:0]});
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) m_reset();
            else m_step();
        end
    end

    // ---------------- scoreboard / compare ----------------
    int vcount = 0;
    logic cap_en = 1'b0, got = 1'b0;
    logic [8:0] got_pix = '0;

    initial begin
        logic [28:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                chk("pixel_valid", cap.pixel_valid, m_pv);
                chk("row", cap.row, 32'(m_row));
                chk("col", cap.col, 32'(m_col));
                chk("locked", locked, m_state == 2);
                chk("frame_count", frame_count, 32'(m_fc));
                chk("err_count", err_count, 32'(m_ec));
                if (cap.pixel_valid) begin
                    vcount++;
                    chk("valid_in_active", (cap.row < VA) && (cap.col < HA), 1);
                    if (exp_q.size() == 0) begin
                        chk("pixel_queue_nonempty", 0, 1);
                    end else begin
                        e = exp_q.pop_front();
                        chk("pixel_word", {cap.row, cap.col, cap.pixel}, e);
                    end
                    if (cap_en && cap.row == 10 && cap.col == 20) begin
                        got = 1'b1;
                        got_pix = cap.pixel;
                    end
                end
            end
        end
    end

    // ---------------- transmitter driver ----------------
    int tx_row = 0, tx_col = 0, delay_row = -1, short_row = -1;
    logic rand_rgb = 1'b0, rand_period = 1'b0, stall_on = 1'b0;

    task automatic drive_pins();
        int hs_on, hs_off;
        hs_on  = HSS + ((tx_row == delay_row) ? 3 : 0);
        hs_off = HSE + ((tx_row == delay_row) ? 3 : 0) - ((tx_row == short_row) ? 2 : 0);
        hsync  = !(tx_col >= hs_on && tx_col < hs_off);
        vsync  = !(tx_row >= VSS && tx_row < VSE);
        if (rand_rgb) begin
            {red, green, blue} = 9'($urandom);
        end else begin
            red   = tx_row[2:0];
            green = tx_col[5:3];
            blue  = tx_col[2:0];
        end
    endtask

    task automatic tx_pixel(input int period);
        @(negedge clk);
        drive_pins();
        pixel_en = 1'b1;
        @(negedge clk);
        pixel_en = 1'b0;
        repeat (period - 2) @(negedge clk);
    endtask

    task automatic run_pixels(input int n);
        int bad;
        for (int i = 0; i < n; i++) begin
            tx_pixel(rand_period ? int'($urandom_range(2, 4)) : 2);
            if (delay_row == 3 && tx_row == 3 && tx_col == HSS + 4)
                chk("realign_col", cap.col, HSS);
            if (stall_on && tx_row == 5 && tx_col == 10) begin
                bad = 0;
                repeat (50) begin
                    @(negedge clk);
                    if (cap.pixel_valid) bad++;
                end
                chk("stall_row", cap.row, 5);
                chk("stall_col", cap.col, 9);
                chk("stall_no_valid", bad, 0);
            end
            tx_col++;
            if (tx_col == HT) begin
                tx_col = 0;
                tx_row = (tx_row + 1) % VT;
            end
        end
    endtask

    task automatic run_frames(input int n);
        run_pixels(n * HT * VT);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_row"}, cap.row, 0);
        chk({tag, "_col"}, cap.col, 0);
        chk({tag, "_pv"}, cap.pixel_valid, 0);
        chk({tag, "_pixel"}, cap.pixel, 0);
        chk({tag, "_locked"}, locked, 0);
        chk({tag, "_fc"}, frame_count, 0);
        chk({tag, "_ec"}, err_count, 0);
        chk({tag, "_state"}, state_dbg, SEARCH);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // acquire lock from reset
        run_frames(2);
        chk("lock_after_f2", locked, 0);
        run_frames(1);
        chk("lock_after_f3", locked, 1);
        chk("err_after_f3", err_count, 0);

        // one fully locked frame with coordinate pattern
        cap_en = 1'b1;
        vcount = 0;
        run_frames(1);
        cap_en = 1'b0;
        chk("valid_per_frame", vcount, HA * VA);
        chk("got_10_20", got, 1);
        chk("pix_10_20", got_pix, 9'o224);

        // random pacing, a 50-clk stall and random colour
        rand_period = 1'b1;
        stall_on = 1'b1;
        run_frames(1);
        stall_on = 1'b0;
        rand_rgb = 1'b1;
        run_frames(1);
        rand_rgb = 1'b0;
        run_frames(1);
        rand_period = 1'b0;
        chk("frame_count_4", frame_count, 4);
        chk("err_before_shift", err_count, 0);

        // hsync shifted by 3 pixels on one line
        delay_row = 3;
        run_frames(1);
        delay_row = -1;
        chk("shift_err", err_count, 1);
        chk("shift_unlock", locked, 0);
        run_frames(1);
        chk("relock_f1", locked, 0);
        run_frames(1);
        chk("relock_f2", locked, 1);

        // hsync pulse shortened by 2 pixels on one line
        short_row = 4;
        run_frames(1);
        short_row = -1;
`ifdef VGA_SYNC_WIDTH_CHECK_EN
        chk("short_locked", locked, 0);
        chk("short_err", err_count, 2);
`else
        chk("short_locked", locked, 1);
        chk("short_err", err_count, 1);
`endif
        run_frames(2);
        chk("locked_before_rst", locked, 1);

        // asynchronous reset mid-line, then relock
        run_pixels($urandom_range(HT * 3 + 5, HT * 8 - 5));
        @(negedge clk);
        #2 rst = 1'b1;
        #1 chk_all_zero("async_rst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        tx_row = 0;
        tx_col = 0;
        run_frames(2);
        chk("rst_relock_f2", locked, 0);
        run_frames(1);
        chk("rst_relock_f3", locked, 1);
        repeat (4) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
